// File: rtl/axi_stream_fifo_pkg.sv
// Shared helpers for the PS->PL stream FIFO: width arithmetic, the release-flag
// encoding and the elaboration-time DEPTH check.
`define AXIS_FIFO_CHECK_DEPTH(depth) \
    if (((depth) < 4) || (((depth) & ((depth) - 1)) != 0)) begin : g_bad_depth \
        $error("axi_stream_ps2pl_fifo: DEPTH must be a power of two and at least 4"); \
    end

package axi_stream_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Each stored beat is {tlast, tdata}.
    function automatic int beat_width(input int data_width);
        return data_width + 1;
    endfunction

    typedef enum logic {
        REL_HOLD  = 1'b0,
        REL_DRAIN = 1'b1
    } rel_state_t;

endpackage

// File: rtl/axi_stream_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read so the
// head entry is visible without a read cycle (first-word fall-through).
module axi_stream_fifo_ram
    import axi_stream_fifo_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_ps2pl_fifo.sv
// AXI4-Stream buffer between the PS DMA MM2S stream and the PL datapath, with
// optional store-and-forward on TLAST and fill-level / packet-count reporting.
module axi_stream_ps2pl_fifo
    import axi_stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int PACKET_MODE = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    output logic                    S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                    S_AXIS_TLAST,
    input  logic                    S_AXIS_TVALID,
    output logic                    M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic [clog2(DEPTH):0]   FIFO_LEVEL,
    output logic [clog2(DEPTH):0]   PKT_COUNT
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = beat_width(DATA_WIDTH);

    `AXIS_FIFO_CHECK_DEPTH(DEPTH)

    if (DATA_WIDTH < 8) begin : g_bad_width
        $error("axi_stream_ps2pl_fifo: DATA_WIDTH must be at least 8");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] pkt_count;
    logic [BW-1:0] rd_beat;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          wr_last;
    logic          rd_last;
    rel_state_t    rel_state;
    rel_state_t    rel_next;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Ready depends only on stored state; a read in the same cycle never frees a slot early.
    assign S_AXIS_TREADY = ~ARESET & ~full;
    assign M_AXIS_TVALID = ~empty & ((PACKET_MODE == 0) || (pkt_count != '0) || (rel_state == REL_DRAIN));

    assign wr_en   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign rd_en   = M_AXIS_TVALID & M_AXIS_TREADY;
    assign wr_last = wr_en & S_AXIS_TLAST;
    assign rd_last = rd_en & M_AXIS_TLAST;

    axi_stream_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (ACLK),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );

    assign M_AXIS_TDATA = rd_beat[DATA_WIDTH-1:0];
    assign M_AXIS_TLAST = rd_beat[DATA_WIDTH];
    assign FIFO_LEVEL   = level;
    assign PKT_COUNT    = pkt_count;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            case ({wr_last, rd_last})
                2'b10:   pkt_count <= pkt_count + LW'(1);
                2'b01:   pkt_count <= pkt_count - LW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // A packet that fills the whole buffer without a TLAST would deadlock the
    // store-and-forward hold, so it is let through cut-through until its TLAST leaves.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rel_state <= REL_HOLD;
        end else begin
            rel_state <= rel_next;
        end
    end

    always_comb begin
        rel_next = rel_state;
        case (rel_state)
            REL_HOLD: begin
                if ((PACKET_MODE != 0) && full && (pkt_count == '0)) begin
                    rel_next = REL_DRAIN;
                end
            end
            REL_DRAIN: begin
                if (rd_last) begin
                    rel_next = REL_HOLD;
                end
            end
            default: rel_next = REL_HOLD;
        endcase
    end

endmodule

// File: tb/tb_axi_stream_ps2pl_fifo.sv
// Bench for axi_stream_ps2pl_fifo: a cut-through and a packet-mode instance
// (DEPTH=8) checked against a queue of the beats the bench drove.
module tb_axi_stream_ps2pl_fifo;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int LW  = 4;

    typedef logic [DW:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          c_s_tready, c_s_tlast, c_s_tvalid, c_m_tvalid, c_m_tlast, c_m_tready;
    logic [DW-1:0] c_s_tdata, c_m_tdata;
    logic [LW-1:0] c_level, c_pkt;
    logic          p_s_tready, p_s_tlast, p_s_tvalid, p_m_tvalid, p_m_tlast, p_m_tready;
    logic [DW-1:0] p_s_tdata, p_m_tdata;
    logic [LW-1:0] p_level, p_pkt;

    axi_stream_ps2pl_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .PACKET_MODE(0)) dut_ct (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TREADY(c_s_tready), .S_AXIS_TDATA(c_s_tdata), .S_AXIS_TLAST(c_s_tlast),
        .S_AXIS_TVALID(c_s_tvalid), .M_AXIS_TVALID(c_m_tvalid), .M_AXIS_TDATA(c_m_tdata),
        .M_AXIS_TLAST(c_m_tlast), .M_AXIS_TREADY(c_m_tready),
        .FIFO_LEVEL(c_level), .PKT_COUNT(c_pkt)
    );

    axi_stream_ps2pl_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .PACKET_MODE(1)) dut_pk (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TREADY(p_s_tready), .S_AXIS_TDATA(p_s_tdata), .S_AXIS_TLAST(p_s_tlast),
        .S_AXIS_TVALID(p_s_tvalid), .M_AXIS_TVALID(p_m_tvalid), .M_AXIS_TDATA(p_m_tdata),
        .M_AXIS_TLAST(p_m_tlast), .M_AXIS_TREADY(p_m_tready),
        .FIFO_LEVEL(p_level), .PKT_COUNT(p_pkt)
    );

    int checks   = 0;
    int failures = 0;

    beat_t exp_c[$];
    beat_t got_c[$];
    beat_t exp_p[$];
    beat_t got_p[$];

    // Output handshakes are stable at the falling edge and complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (c_m_tvalid && c_m_tready) got_c.push_back({c_m_tlast, c_m_tdata});
            if (p_m_tvalid && p_m_tready) got_p.push_back({p_m_tlast, p_m_tdata});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait for its handshake; leaves TVALID asserted so
    // consecutive calls stream without bubbles.
    task automatic send(input int sel, input logic [DW-1:0] d, input logic l);
        logic acc;
        int   n;
        n = 0;
        if (sel == 0) begin
            c_s_tvalid = 1'b1; c_s_tdata = d; c_s_tlast = l;
        end else begin
            p_s_tvalid = 1'b1; p_s_tdata = d; p_s_tlast = l;
        end
        forever begin
            @(negedge clk);
            acc = (sel == 0) ? c_s_tready : p_s_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (sel == 0) exp_c.push_back({l, d});
                else          exp_p.push_back({l, d});
                return;
            end
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout: dut %0d never accepted beat %h", sel, d);
                return;
            end
        end
    endtask

    task automatic test_reset();
        c_m_tready = 1'b0;
        send(0, 32'hA0, 1'b0);
        send(0, 32'hA1, 1'b1);
        send(0, 32'hA2, 1'b0);
        rst = 1'b1;
        #2;
        checks++; if (c_s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b want 0", c_s_tready); end
        checks++; if (c_m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", c_m_tvalid); end
        checks++; if (c_level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", c_level); end
        checks++; if (c_pkt !== 4'd0) begin failures++; $display("FAIL reset_pkt: got %0d want 0", c_pkt); end
        c_s_tvalid = 1'b0;
        tick();
        rst = 1'b0;
        exp_c.delete(); got_c.delete(); exp_p.delete(); got_p.delete();
        #2;
        checks++; if (c_s_tready !== 1'b1) begin failures++; $display("FAIL reset_release_tready: got %b want 1", c_s_tready); end
        checks++; if (c_m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_release_tvalid: got %b want 0", c_m_tvalid); end
        checks++; if (p_s_tready !== 1'b1) begin failures++; $display("FAIL reset_release_pk_tready: got %b want 1", p_s_tready); end
        tick();
    endtask

    task automatic test_cut_through();
        beat_t e, g;
        int    start;
        c_m_tready = 1'b1;
        c_s_tvalid = 1'b1; c_s_tdata = 32'h11; c_s_tlast = 1'b0;
        #2;
        checks++; if (c_m_tvalid !== 1'b0) begin failures++; $display("FAIL ct_empty_valid: got %b want 0", c_m_tvalid); end
        tick();
        exp_c.push_back({1'b0, 32'h11});
        c_s_tvalid = 1'b0;
        checks++; if (c_m_tvalid !== 1'b1) begin failures++; $display("FAIL ct_latency_valid: got %b want 1", c_m_tvalid); end
        checks++; if (c_m_tdata !== 32'h11) begin failures++; $display("FAIL ct_latency_data: got %h want 11", c_m_tdata); end
        tick();
        start = cyc;
        for (int i = 0; i < 100; i++) send(0, DW'(i), (i == 99));
        checks++; if (cyc - start != 100) begin failures++; $display("FAIL ct_throughput: got %0d cycles want 100", cyc - start); end
        c_s_tvalid = 1'b0;
        repeat (3) tick();
        checks++; if (got_c.size() != 101) begin failures++; $display("FAIL ct_count: got %0d beats want 101", got_c.size()); end
        while (exp_c.size() > 0) begin
            e = exp_c.pop_front();
            checks++;
            if (got_c.size() == 0) begin failures++; $display("FAIL ct_missing: got none want %h", e); end
            else begin
                g = got_c.pop_front();
                if (g !== e) begin failures++; $display("FAIL ct_order: got %h want %h", g, e); end
            end
        end
        checks++; if (c_level !== 4'd0) begin failures++; $display("FAIL ct_level_end: got %0d want 0", c_level); end
        got_c.delete();
    endtask

    task automatic test_full_wrap();
        beat_t e, g;
        c_m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 32'd100 + DW'(i), 1'b0);
        checks++; if (c_level !== 4'd8) begin failures++; $display("FAIL full_level: got %0d want 8", c_level); end
        checks++; if (c_s_tready !== 1'b0) begin failures++; $display("FAIL full_tready: got %b want 0", c_s_tready); end
        c_s_tvalid = 1'b1; c_s_tdata = 32'd108; c_s_tlast = 1'b0;
        repeat (2) tick();
        checks++; if (c_level !== 4'd8) begin failures++; $display("FAIL full_hold_level: got %0d want 8", c_level); end
        c_m_tready = 1'b1;
        #2;
        checks++; if (c_s_tready !== 1'b0) begin failures++; $display("FAIL full_same_cycle_read: got %b want 0", c_s_tready); end
        tick();
        checks++; if (c_level !== 4'd7) begin failures++; $display("FAIL full_after_read_level: got %0d want 7", c_level); end
        checks++; if (c_s_tready !== 1'b1) begin failures++; $display("FAIL full_after_read_tready: got %b want 1", c_s_tready); end
        for (int i = 8; i < 20; i++) send(0, 32'd100 + DW'(i), 1'b0);
        c_s_tvalid = 1'b0;
        repeat (12) tick();
        checks++; if (got_c.size() != 20) begin failures++; $display("FAIL wrap_count: got %0d beats want 20", got_c.size()); end
        for (int i = 0; i < 20; i++) begin
            e = {1'b0, 32'd100 + DW'(i)};
            checks++;
            if (got_c.size() == 0) begin failures++; $display("FAIL wrap_missing: got none want %h", e); end
            else begin
                g = got_c.pop_front();
                if (g !== e) begin failures++; $display("FAIL wrap_order: got %h want %h", g, e); end
            end
        end
        exp_c.delete(); got_c.delete();
    endtask

    task automatic test_simultaneous();
        beat_t e, g;
        c_m_tready = 1'b0;
        send(0, 32'd200, 1'b1);
        send(0, 32'd201, 1'b0);
        send(0, 32'd202, 1'b0);
        send(0, 32'd203, 1'b0);
        c_s_tvalid = 1'b0;
        checks++; if (c_level !== 4'd4) begin failures++; $display("FAIL sim_pre_level: got %0d want 4", c_level); end
        checks++; if (c_pkt !== 4'd1) begin failures++; $display("FAIL sim_pre_pkt: got %0d want 1", c_pkt); end
        c_m_tready = 1'b1;
        send(0, 32'd204, 1'b1);
        c_s_tvalid = 1'b0; c_m_tready = 1'b0;
        checks++; if (c_level !== 4'd4) begin failures++; $display("FAIL sim_level: got %0d want 4", c_level); end
        checks++; if (c_pkt !== 4'd1) begin failures++; $display("FAIL sim_pkt_last_both: got %0d want 1", c_pkt); end
        c_m_tready = 1'b1;
        send(0, 32'd205, 1'b0);
        c_s_tvalid = 1'b0; c_m_tready = 1'b0;
        checks++; if (c_level !== 4'd4) begin failures++; $display("FAIL sim_level2: got %0d want 4", c_level); end
        checks++; if (c_pkt !== 4'd1) begin failures++; $display("FAIL sim_pkt_no_last: got %0d want 1", c_pkt); end
        c_m_tready = 1'b1;
        repeat (6) tick();
        checks++; if (c_level !== 4'd0) begin failures++; $display("FAIL sim_drain_level: got %0d want 0", c_level); end
        checks++; if (c_pkt !== 4'd0) begin failures++; $display("FAIL sim_drain_pkt: got %0d want 0", c_pkt); end
        while (exp_c.size() > 0) begin
            e = exp_c.pop_front();
            checks++;
            if (got_c.size() == 0) begin failures++; $display("FAIL sim_missing: got none want %h", e); end
            else begin
                g = got_c.pop_front();
                if (g !== e) begin failures++; $display("FAIL sim_order: got %h want %h", g, e); end
            end
        end
        got_c.delete();
    endtask

    task automatic test_packet();
        beat_t e, g;
        p_m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1, 32'd300 + DW'(i), 1'b0);
            p_s_tvalid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                checks++; if (p_m_tvalid !== 1'b0) begin failures++; $display("FAIL pkt_held_valid: got %b want 0 after beat %0d", p_m_tvalid, i); end
                @(posedge clk); #1;
            end
        end
        #2;
        checks++; if (p_m_tvalid !== 1'b0) begin failures++; $display("FAIL pkt_held_before_last: got %b want 0", p_m_tvalid); end
        send(1, 32'd304, 1'b1);
        p_s_tvalid = 1'b0;
        checks++; if (p_m_tvalid !== 1'b1) begin failures++; $display("FAIL pkt_valid_rise: got %b want 1", p_m_tvalid); end
        checks++; if (p_pkt !== 4'd1) begin failures++; $display("FAIL pkt_count_one: got %0d want 1", p_pkt); end
        repeat (6) tick();
        checks++; if (p_pkt !== 4'd0) begin failures++; $display("FAIL pkt_count_zero: got %0d want 0", p_pkt); end
        checks++; if (p_level !== 4'd0) begin failures++; $display("FAIL pkt_level_zero: got %0d want 0", p_level); end
        checks++; if (got_p.size() != 5) begin failures++; $display("FAIL pkt_beats: got %0d want 5", got_p.size()); end
        while (exp_p.size() > 0) begin
            e = exp_p.pop_front();
            checks++;
            if (got_p.size() == 0) begin failures++; $display("FAIL pkt_missing: got none want %h", e); end
            else begin
                g = got_p.pop_front();
                if (g !== e) begin failures++; $display("FAIL pkt_order: got %h want %h", g, e); end
            end
        end
        got_p.delete();
    endtask

    task automatic test_oversize();
        beat_t e, g;
        p_m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(1, 32'd400 + DW'(i), 1'b0);
        checks++; if (p_level !== 4'd8) begin failures++; $display("FAIL big_level: got %0d want 8", p_level); end
        checks++; if (p_m_tvalid !== 1'b0) begin failures++; $display("FAIL big_valid_at_full: got %b want 0", p_m_tvalid); end
        for (int i = 8; i < 12; i++) send(1, 32'd400 + DW'(i), (i == 11));
        p_s_tvalid = 1'b0;
        repeat (14) tick();
        checks++; if (got_p.size() != 12) begin failures++; $display("FAIL big_beats: got %0d want 12", got_p.size()); end
        while (exp_p.size() > 0) begin
            e = exp_p.pop_front();
            checks++;
            if (got_p.size() == 0) begin failures++; $display("FAIL big_missing: got none want %h", e); end
            else begin
                g = got_p.pop_front();
                if (g !== e) begin failures++; $display("FAIL big_order: got %h want %h", g, e); end
            end
        end
        got_p.delete();
        send(1, 32'd500, 1'b0);
        send(1, 32'd501, 1'b0);
        p_s_tvalid = 1'b0;
        repeat (2) tick();
        checks++; if (p_m_tvalid !== 1'b0) begin failures++; $display("FAIL big_release_cleared: got %b want 0", p_m_tvalid); end
        checks++; if (p_level !== 4'd2) begin failures++; $display("FAIL big_short_level: got %0d want 2", p_level); end
        send(1, 32'd502, 1'b1);
        p_s_tvalid = 1'b0;
        repeat (5) tick();
        while (exp_p.size() > 0) begin
            e = exp_p.pop_front();
            checks++;
            if (got_p.size() == 0) begin failures++; $display("FAIL short_missing: got none want %h", e); end
            else begin
                g = got_p.pop_front();
                if (g !== e) begin failures++; $display("FAIL short_order: got %h want %h", g, e); end
            end
        end
        checks++; if (got_p.size() != 0) begin failures++; $display("FAIL short_extra: got %0d extra beats want 0", got_p.size()); end
    endtask

    initial begin
        c_s_tvalid = 1'b0; c_s_tdata = '0; c_s_tlast = 1'b0; c_m_tready = 1'b0;
        p_s_tvalid = 1'b0; p_s_tdata = '0; p_s_tlast = 1'b0; p_m_tready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        test_reset();
        test_cut_through();
        test_full_wrap();
        test_simultaneous();
        test_packet();
        test_oversize();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
